// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks program memory, assembles one- and two-byte
// instructions and hands them to the decoder over a valid/ready handshake.
module fetch_unit #(
  parameter logic [7:0] ResetPc = 8'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [7:0]  pmem_addr_o,
  input  logic [7:0]  pmem_data_i,
  input  logic        enable_i,
  output logic [15:0] instr_o,
  output logic        instr_two_o,
  output logic [7:0]  instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [7:0]  redirect_pc_i
);

  typedef enum logic [1:0] {StFetch0, StFetch1, StHold} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic        two_q, two_d;
  logic [7:0]  ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        is_two;

  // MOV_IMM/CMP_IMM (1000xxxx) and branches (101xxxxx) carry an operand byte.
  assign is_two = (pmem_data_i[7:4] == 4'b1000) || (pmem_data_i[7:5] == 3'b101);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    two_d   = two_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (redirect_i) begin
      // Redirect beats everything, including a half-assembled two-byte fetch.
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
      state_d = StFetch0;
    end else begin
      unique case (state_q)
        StFetch0: begin
          if (enable_i) begin
            instr_d[15:8] = pmem_data_i;
            ipc_d         = pc_q;
            pc_d          = pc_q + 8'd1;
            if (is_two) begin
              state_d = StFetch1;
            end else begin
              instr_d[7:0] = 8'h00;
              two_d        = 1'b0;
              valid_d      = 1'b1;
              state_d      = StHold;
            end
          end
        end
        StFetch1: begin
          if (enable_i) begin
            instr_d[7:0] = pmem_data_i;
            two_d        = 1'b1;
            valid_d      = 1'b1;
            pc_d         = pc_q + 8'd1;
            state_d      = StHold;
          end
        end
        StHold: begin
          if (instr_ready_i) begin
            valid_d = 1'b0;
            state_d = StFetch0;
          end
        end
        default: state_d = StFetch0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch0;
      pc_q    <= ResetPc;
      instr_q <= 16'h0000;
      two_q   <= 1'b0;
      ipc_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      two_q   <= two_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign pmem_addr_o   = pc_q;
  assign instr_o       = instr_q;
  assign instr_two_o   = two_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: directed program-memory contents, a queue of
// expected transfers, and a negedge monitor that pops on every valid&&ready.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  pmem_addr_o;
  logic [7:0]  pmem_data_i;
  logic        enable_i = 1'b1;
  logic [15:0] instr_o;
  logic        instr_two_o;
  logic [7:0]  instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [7:0]  redirect_pc_i = 8'h00;

  logic [7:0]  rom [256];
  logic [24:0] exp_q [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk_i = ~clk_i;
  assign pmem_data_i = rom[pmem_addr_o];

  fetch_unit #(.ResetPc(8'd0)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pmem_addr_o  (pmem_addr_o),
    .pmem_data_i  (pmem_data_i),
    .enable_i     (enable_i),
    .instr_o      (instr_o),
    .instr_two_o  (instr_two_o),
    .instr_pc_o   (instr_pc_o),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid&&ready here.
  always @(negedge clk_i) begin
    if (!rst_i && instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer: got %0h pc %0h want none", instr_o, instr_pc_o);
      end else begin
        check("xfer", {7'd0, instr_o, instr_two_o, instr_pc_o}, {7'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid_o && n < 10) begin
      tick();
      n++;
    end
    if (!instr_valid_o) begin
      total++;
      bad++;
      $display("FAIL %s: got valid=0 want valid=1 within 10 cycles", name);
    end
  endtask

  task automatic accept();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  task automatic do_redirect(input logic [7:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h70;
    rom[0]   = 8'h81; rom[1]  = 8'h00;
    rom[4]   = 8'h98; rom[5]  = 8'h32;
    rom[9]   = 8'hB4; rom[10] = 8'h55;
    rom[13]  = 8'h85; rom[14] = 8'h3C;
    rom[255] = 8'hA8;

    // Reset values
    #2;
    check("rst_addr", pmem_addr_o, 8'h00);
    check("rst_valid", instr_valid_o, 1'b0);
    check("rst_instr", instr_o, 16'h0000);
    check("rst_two", instr_two_o, 1'b0);
    check("rst_ipc", instr_pc_o, 8'h00);

    // Two-byte MOV_IMM first after reset
    exp_q.push_back({16'h8100, 1'b1, 8'h00});
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    tick();
    check("t1_valid_e1", instr_valid_o, 1'b0);
    tick();
    check("t1_valid_e2", instr_valid_o, 1'b1);
    check("t1_addr", pmem_addr_o, 8'h02);
    tick();
    instr_ready_i = 1'b0;

    // Redirect to one-byte INPUT at 4
    exp_q.push_back({16'h9800, 1'b0, 8'h04});
    do_redirect(8'h04);
    check("t2_addr_redir", pmem_addr_o, 8'h04);
    check("t2_valid_redir", instr_valid_o, 1'b0);
    tick();
    check("t2_valid_e1", instr_valid_o, 1'b1);
    check("t2_addr", pmem_addr_o, 8'h05);
    accept();

    // Backpressure in HOLD
    exp_q.push_back({16'h3200, 1'b0, 8'h05});
    wait_valid("t3_valid");
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_instr", instr_o, 16'h3200);
      check("t3_hold_ipc", instr_pc_o, 8'h05);
      check("t3_hold_valid", instr_valid_o, 1'b1);
      check("t3_hold_addr", pmem_addr_o, 8'h06);
      tick();
    end
    accept();
    check("t3_after_xfer", instr_valid_o, 1'b0);

    // Redirect while in FETCH1 of 0xB4 at 9
    do_redirect(8'h09);
    tick();
    check("t4_f1_valid", instr_valid_o, 1'b0);
    check("t4_f1_addr", pmem_addr_o, 8'h0A);
    exp_q.push_back({16'h853C, 1'b1, 8'h0D});
    do_redirect(8'h0D);
    check("t4_redir_valid", instr_valid_o, 1'b0);
    check("t4_redir_addr", pmem_addr_o, 8'h0D);
    wait_valid("t4_valid");
    accept();

    // PC wrap: two-byte at 0xFF takes operand from 0x00
    rom[0] = 8'h1A;
    exp_q.push_back({16'hA81A, 1'b1, 8'hFF});
    do_redirect(8'hFF);
    wait_valid("t5_valid");
    check("t5_addr", pmem_addr_o, 8'h01);
    accept();

    // enable=0 in FETCH0 freezes fetch
    enable_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_en0_valid", instr_valid_o, 1'b0);
      check("t6_en0_addr", pmem_addr_o, 8'h01);
    end
    enable_i = 1'b1;
    wait_valid("t6_valid");
    check("t6_instr", instr_o, 16'h0000);
    check("t6_ipc", instr_pc_o, 8'h01);

    // redirect && ready in HOLD: transfer completes, redirect applied
    exp_q.push_back({16'h0000, 1'b0, 8'h01});
    instr_ready_i = 1'b1;
    do_redirect(8'h04);
    instr_ready_i = 1'b0;
    check("t7_valid", instr_valid_o, 1'b0);
    check("t7_addr", pmem_addr_o, 8'h04);
    wait_valid("t7_valid2");
    check("t7_instr", instr_o, 16'h9800);

    // Async reset mid-HOLD, between edges
    #2;
    rst_i = 1'b1;
    #1;
    check("t8_valid", instr_valid_o, 1'b0);
    check("t8_addr", pmem_addr_o, 8'h00);
    check("t8_instr", instr_o, 16'h0000);
    tick();

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the 8-bit core. Drives the program memory address bus and reads its combinational data bus. Assembles one- and two-byte instructions and presents each to the decoder over a valid/ready handshake. Accepts branch redirects from the execute stage and discards any partially fetched instruction.

## Interface
- RESET_PC, 8'd0, fetch address loaded at reset.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pmem_addr  out  8  program memory address; equals internal pc register.
- pmem_data  in  8  program memory read data, combinational from pmem_addr.
- enable  in  1  fetch enable; low freezes fetch states (HOLD unaffected).
- instr  out  16  {opcode byte, operand byte}; operand byte 8'h00 for one-byte instructions.
- instr_two  out  1  1 = two-byte instruction.
- instr_pc  out  8  address of the opcode byte of instr.
- instr_valid  out  1  instr/instr_two/instr_pc valid.
- instr_ready  in  1  decoder accepts; transfer when valid && ready at a rising edge.
- redirect  in  1  branch taken; load redirect_pc.
- redirect_pc  in  8  new fetch address.

## Operation
- Length decode on the opcode byte b: two-byte iff b[7:4]==4'b1000 (MOV_IMM, CMP_IMM) or b[7:5]==3'b101 (BRA, BHI, BEQ). All other bytes are one-byte, including 1001xxxx (INC/DEC/INPUT/OUTPUT), NOP 8'h70 and 4-bit register ops.
- States: FETCH0, FETCH1, HOLD. Reset state is FETCH0.
- FETCH0 (enable=1): instr[15:8]<=pmem_data; instr_pc<=pc; pc<=pc+1.
  - If two-byte: next state FETCH1.
  - Else: instr[7:0]<=0, instr_two<=0, instr_valid<=1, next state HOLD.
- FETCH1 (enable=1): instr[7:0]<=pmem_data; instr_two<=1; instr_valid<=1; pc<=pc+1; next state HOLD.
- enable=0 in FETCH0/FETCH1: no capture, pc and state unchanged.
- HOLD: outputs stable while instr_ready=0. On instr_ready=1: instr_valid<=0, next state FETCH0.
- redirect=1 has highest priority in every state: pc<=redirect_pc, instr_valid<=0, next state FETCH0. A partial FETCH1 is discarded.
  - redirect && instr_ready in HOLD: the transfer completes and the redirect is still applied.
  - redirect is honoured regardless of enable.
- pc is 8-bit and wraps 8'hFF -> 8'h00. A two-byte instruction at 8'hFF takes its operand from address 8'h00.

## Timing
- Reset (asynchronous, immediate) sets: pc=RESET_PC, pmem_addr=RESET_PC, instr=16'h0000, instr_two=0, instr_pc=8'h00, instr_valid=0, state FETCH0.
- One-byte instruction: instr_valid high after 1 rising edge from entering FETCH0.
- Two-byte instruction: instr_valid high after 2 rising edges.
- First instruction after reset deassertion: valid after edge 1 (one-byte) or edge 2 (two-byte).
- Throughput with instr_ready held at 1: one-byte instruction every 2 cycles; two-byte every 3 cycles.
- Redirect: pmem_addr=redirect_pc in the cycle after the redirect edge. First valid from the new stream 1 or 2 edges later.
- pmem_addr changes only at rising edges or on asynchronous reset. It is never combinationally dependent on inputs.
- All outputs are registered.

## Test plan
- ROM[0..1]=8'h81,8'h00 (MOV_IMM R1,0); release reset; ready=1 -> valid after edge 2: instr=16'h8100, instr_two=1, instr_pc=0; pmem_addr=2.
- ROM[4]=8'h98 (INPUT R0); redirect to 4 -> valid: instr=16'h9800, instr_two=0, instr_pc=4; next pmem_addr=5.
- Backpressure: ready=0 for 5 cycles in HOLD -> instr, instr_pc, instr_valid constant; pmem_addr constant; one transfer only when ready=1.
- Redirect while in FETCH1 of 8'hB4 at address 9, redirect_pc=13 -> no valid for address 9; next valid has instr_pc=13.
- Wrap: ROM[255]=8'hA8, ROM[0]=8'h1A; redirect to 255 -> instr=16'hA81A, instr_two=1, instr_pc=255; then pmem_addr=1.
- Async reset asserted mid-HOLD between edges -> instr_valid=0 and pmem_addr=RESET_PC immediately. Also check: enable=0 in FETCH0 for 3 cycles -> no valid, pc frozen.
